// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver: 5-8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_VOTE_EN to take each bit decision as a 2-of-3 vote over samples 7, 8 and 9.
module uart_receiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       two_stop_bits,
  input  logic [1:0] word_length,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] DEC_SAMPLE = 4'd9;
`else
  localparam logic [3:0] DEC_SAMPLE = 4'd8;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, BREAK} state_t;

  state_t           state;
  logic             rx_p0, rx_s;
  logic [PRE_W-1:0] presc;
  logic [3:0]       cnt;
  logic [3:0]       nbits;
  logic [7:0]       shreg;
  logic             par_acc, par_bad, stop_bad;
  logic             pen_l, two_l;
  logic [1:0]       wl_l;
  logic             tick, dec, wrap, bit_val;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // stage p0/p1: two-flop synchronizer, idles high
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  assign tick = (state != IDLE) && (presc == PRE_W'(DIV - 1));
  assign dec  = tick && (cnt == DEC_SAMPLE);
  assign wrap = tick && (cnt == 4'd15);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic s7, s8;
  always_ff @(posedge clk) begin
    if (tick && cnt == 4'd7) s7 <= rx_s;
    if (tick && cnt == 4'd8) s8 <= rx_s;
  end
  assign bit_val = maj3(s7, s8, rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      presc      <= '0;
      cnt        <= '0;
      nbits      <= '0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      pen_l      <= 1'b0;
      two_l      <= 1'b0;
      wl_l       <= 2'd0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (state != IDLE) begin
        presc <= tick ? '0 : presc + PRE_W'(1);
        if (tick) cnt <= cnt + 4'd1;
      end
      case (state)
        IDLE: if (!rx_s) begin
          state    <= START;
          presc    <= '0;
          cnt      <= '0;
          nbits    <= '0;
          par_acc  <= 1'b0;
          par_bad  <= 1'b0;
          stop_bad <= 1'b0;
          pen_l    <= parity_en;
          two_l    <= two_stop_bits;
          wl_l     <= word_length;
          rx_busy  <= 1'b1;
        end
        START: begin
          if (dec && bit_val) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else if (wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (dec) begin
            shreg   <= {bit_val, shreg[7:1]};
            par_acc <= par_acc ^ bit_val;
            nbits   <= nbits + 4'd1;
          end
          if (wrap && nbits == (4'd5 + {2'b00, wl_l})) state <= pen_l ? PARITY : STOP1;
        end
        PARITY: begin
          if (dec) par_bad <= bit_val ^ par_acc;
          if (wrap) state <= STOP1;
        end
        // the final stop bit goes to DONE straight from its decision so a back-to-back start is not missed
        STOP1: begin
          if (dec) begin
            if (!bit_val) stop_bad <= 1'b1;
            if (!two_l) state <= DONE;
          end
          if (wrap) state <= STOP2;
        end
        STOP2: if (dec) begin
          if (!bit_val) stop_bad <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          data_out   <= shreg >> (2'd3 - wl_l);
          parity_err <= par_bad;
          frame_err  <= stop_bad;
          data_valid <= 1'b1;
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else begin
            state <= BREAK;
          end
        end
        BREAK: if (rx_s) begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per... 4 clocks per tick, 64 clocks per bit.
module tb_uart_receiver;
  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic       parity_en;
  logic       two_stop_bits;
  logic [1:0] word_length;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  int n_checks = 0;
  int n_err    = 0;
  int vld_count = 0;
  int wide_count = 0;
  int v0;
  logic prev_vld = 1'b0;
  logic busy_seen = 1'b0;

  uart_receiver #(.CLK_FREQ(6_400_000), .BAUD_RATE(100_000), .OVERSAMPLE(16)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .parity_en(parity_en), .two_stop_bits(two_stop_bits),
    .word_length(word_length), .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      vld_count = vld_count + 1;
      if (prev_vld) wide_count = wide_count + 1;
    end
    if (rx_busy) busy_seen = 1'b1;
    prev_vld = data_valid;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit pbit,
                            input bit two, input bit s1, input bit s2,
                            input int glitch_bit, input int abort_bit);
    word_length   = 2'(nb - 5);
    parity_en     = pen;
    two_stop_bits = two;
    drive(1'b0, BIT);
    for (int i = 0; i < nb; i++) begin
      if (i == abort_bit) begin
        drive(d[i], 32);
        rstn = 1'b0;
        drive(d[i], 1);
        rstn = 1'b1;
        rx   = 1'b1;
        return;
      end else if (i == glitch_bit) begin
        drive(d[i], 34);
        drive(1'b0, 4);
        drive(d[i], 26);
      end else begin
        drive(d[i], BIT);
      end
    end
    if (pen) drive(pbit, BIT);
    drive(s1, BIT);
    if (two) drive(s2, BIT);
  endtask

  initial begin
    rx = 1'b1; rstn = 1'b0; parity_en = 1'b0; two_stop_bits = 1'b0; word_length = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", int'(data_out), 0);
    check("rst_valid", int'(data_valid), 0);
    check("rst_perr", int'(parity_err), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_busy", int'(rx_busy), 0);
    rstn = 1'b1;
    drive(1'b1, 20);

    // 8N1 0xA5
    v0 = vld_count; busy_seen = 1'b0;
    send_frame(8'hA5, 8, 0, 0, 0, 1, 1, -1, -1);
    drive(1'b1, 8);
    check("a5_count", vld_count - v0, 1);
    check("a5_data", int'(data_out), 'hA5);
    check("a5_perr", int'(parity_err), 0);
    check("a5_ferr", int'(frame_err), 0);
    check("a5_busy_idle", int'(rx_busy), 0);
    check("a5_busy_seen", int'(busy_seen), 1);
    check("a5_pulse_width", wide_count, 0);

    // 7E1: 0x35 has four ones, so the correct even parity bit is 0
    v0 = vld_count;
    send_frame(8'h35, 7, 1, 0, 0, 1, 1, -1, -1);
    drive(1'b1, 8);
    check("p0_count", vld_count - v0, 1);
    check("p0_data", int'(data_out), 'h35);
    check("p0_perr", int'(parity_err), 0);
    v0 = vld_count;
    send_frame(8'h35, 7, 1, 1, 0, 1, 1, -1, -1);
    drive(1'b1, 8);
    check("p1_count", vld_count - v0, 1);
    check("p1_data", int'(data_out), 'h35);
    check("p1_perr", int'(parity_err), 1);
    check("p1_ferr", int'(frame_err), 0);

    // short words right-justified
    send_frame(8'h1F, 5, 0, 0, 0, 1, 1, -1, -1);
    drive(1'b1, 8);
    check("w5_data", int'(data_out), 'h1F);
    check("w5_perr", int'(parity_err), 0);
    send_frame(8'h2A, 6, 0, 0, 0, 1, 1, -1, -1);
    drive(1'b1, 8);
    check("w6_data", int'(data_out), 'h2A);

    // two stop bits, second one low, then line held low
    v0 = vld_count;
    send_frame(8'hC3, 8, 0, 0, 1, 1, 0, -1, -1);
    drive(1'b0, 3 * BIT);
    check("brk_count", vld_count - v0, 1);
    check("brk_data", int'(data_out), 'hC3);
    check("brk_ferr", int'(frame_err), 1);
    check("brk_busy_low", int'(rx_busy), 1);
    drive(1'b1, 2 * BIT);
    check("brk_count_after", vld_count - v0, 1);
    check("brk_busy_idle", int'(rx_busy), 0);

    // reset in the middle of the data bits
    v0 = vld_count;
    send_frame(8'hF0, 8, 0, 0, 0, 1, 1, -1, 4);
    check("abort_data", int'(data_out), 0);
    check("abort_ferr", int'(frame_err), 0);
    check("abort_busy", int'(rx_busy), 0);
    drive(1'b1, 2 * BIT);
    check("abort_count", vld_count - v0, 0);
    send_frame(8'h3C, 8, 0, 0, 0, 1, 1, -1, -1);
    drive(1'b1, 8);
    check("after_abort_count", vld_count - v0, 1);
    check("after_abort_data", int'(data_out), 'h3C);

    // false start: low for 4 ticks only
    v0 = vld_count; busy_seen = 1'b0;
    drive(1'b0, 16);
    drive(1'b1, 2 * BIT);
    check("glitch_count", vld_count - v0, 0);
    check("glitch_busy", int'(rx_busy), 0);
    check("glitch_seen", int'(busy_seen), 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    v0 = vld_count;
    send_frame(8'h55, 8, 0, 0, 0, 1, 1, 0, -1);
    drive(1'b1, 8);
    check("vote_count", vld_count - v0, 1);
    check("vote_data", int'(data_out), 'h55);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Asynchronous serial receiver; the receive-side counterpart of the UART transmitter in the same serial subsystem. Oversamples the `rx` line at 16x baud, validates the start bit, reassembles 5–8 LSB-first data bits, and checks optional even parity and one or two stop bits. Each completed frame is presented as a parallel byte with a one-cycle valid strobe and error flags.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bits/s.
- `OVERSAMPLE`, 16: sample ticks per bit; fixed at 16.

- `clk`  in  1  system clock. One clock domain.
- `rstn`  in  1  reset; synchronous, active-low.
- `rx`  in  1  serial line; asynchronous; idle high.
- `parity_en`  in  1  1 = a parity bit follows the data bits.
- `two_stop_bits`  in  1  1 = two stop bits are expected.
- `word_length`  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- `data_out`  out  8  received word, right-justified; unused upper bits are 0.
- `data_valid`  out  1  one-cycle strobe: a frame has completed.
- `parity_err`  out  1  parity mismatch on the last frame.
- `frame_err`  out  1  a stop bit sampled 0 on the last frame.
- `rx_busy`  out  1  a frame is in progress (any state other than IDLE).

## Operation
- `rx` passes through a 2-FF synchronizer to give `rx_s`; all logic uses `rx_s`.
- Prescaler: DIV = CLK_FREQ/(BAUD_RATE*16), integer floor (651 at the defaults).
  - Counts 0..DIV-1 and emits `tick` at DIV-1.
  - Cleared when a start is detected.
- Sample counter: 0..15, advanced by `tick`. A bit ends when the counter wraps from 15 to 0.
- The bit decision is taken at sample 8 of each bit. In START, the decision is at sample 8 counted from detection, i.e. mid start bit.
- `parity_en`, `two_stop_bits` and `word_length` are latched at start detection. Changes during a frame are ignored.
- State machine:
  - IDLE: `rx_s`==0 → START.
  - START: decision 1 (false start) → IDLE with no output. Decision 0 → DATA, once the sample counter wraps.
  - DATA: shift in N bits, LSB first. After bit N → PARITY if latched parity_en, else STOP1.
  - PARITY: compare against the XOR of the N data bits (even parity) → STOP1.
  - STOP1: decision 0 sets the frame error. Then → STOP2 if latched two_stop_bits, else DONE.
  - STOP2: same check as STOP1 → DONE.
  - DONE: one cycle.
    - Update `data_out`, `parity_err` and `frame_err`; pulse `data_valid`.
    - → IDLE if `rx_s`==1, else → BREAK.
  - BREAK: wait for `rx_s`==1 → IDLE. This prevents re-triggering while the line is held low.
- The error flags hold until the next DONE. A frame is always delivered, even with errors.

## Timing
- Reset values: `data_out`=0x00, `data_valid`=0, `parity_err`=0, `frame_err`=0, `rx_busy`=0, state IDLE, counters 0.
- `rstn` low on any edge aborts a frame in progress immediately. No `data_valid` is issued for the aborted frame.
- Start detection occurs 2 cycles after `rx` falls (synchronizer delay).
- Stop-bit decision to `data_valid`:
  - 1 cycle to enter DONE.
  - Outputs are registered in DONE and visible the next cycle.
- Maximum frame throughput is back-to-back frames. The next start bit may begin right after the final stop-bit sample, because DONE costs 1 cycle and the start is detected from IDLE.
- `rx_busy` is 1 from the cycle after start detection until the cycle after DONE. It is also 1 in BREAK.
- Tolerance: at most ±4% baud mismatch between transmitter and receiver.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined:
  - Each bit decision is the 2-of-3 majority of `rx_s` captured at samples 7, 8 and 9.
  - The decision is taken at sample 9, 1 tick later than without the macro.
- Not defined: single sample of `rx_s` at sample 8.

## Test plan
- 8N1, send 0xA5 → `data_out`=0xA5, one-cycle `data_valid`, `parity_err`=0, `frame_err`=0, `rx_busy` back to 0.
- 7 bits, parity on, send 0x35 with parity bit 0 → no error. Same frame with parity bit 1 → `data_out`=0x35, `parity_err`=1.
- 5 bits, send 0x1F → `data_out`=0x1F (upper bits 0). Repeat with 6 bits and 0x2A → `data_out`=0x2A.
- 8 bits, two stop bits, second stop bit 0 and the line then held low for 3 bit times → `frame_err`=1 on a single `data_valid`; no further frame until `rx` returns high.
- `rx` low glitch for 4 sample ticks → no `data_valid`, state returns to IDLE. With the macro defined: a 1-tick glitch at sample 8 inside a data bit of 0x55 is rejected → `data_out`=0x55.
- `rstn` low for 1 cycle midway through the DATA bits of a frame → all outputs return to reset values, no `data_valid`; a following 0x3C frame is received correctly.
